store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_pkg.sv | 20 ++
 rtl/stbuf_ent.sv | 81 ++++++++
 rtl/store_buffer.sv | 174 +++++++++++++++++
 tb/tb_store_buffer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared constants, entry-state encoding and payload type for the store buffer.
package store_buffer_pkg;

    localparam int unsigned STBUF_ENT_NUM = 4;
    localparam int unsigned STBUF_ENT_SEL = 2;
    localparam int unsigned ADDR_LEN      = 32;
    localparam int unsigned DATA_LEN      = 32;
    localparam int unsigned SPECTAG_LEN   = 5;

    // Entry lifecycle: FREE -> PEND (executed) -> COMM (retired) -> FREE (drained)
    localparam logic [1:0] ST_FREE = 2'b00;
    localparam logic [1:0] ST_PEND = 2'b01;
    localparam logic [1:0] ST_COMM = 2'b10;

    typedef struct packed {
        logic [ADDR_LEN-1:0] addr;
        logic [DATA_LEN-1:0] data;
    } stbuf_payload_t;

endpackage

// File: rtl/stbuf_ent.sv
// One store-buffer entry: payload storage, lifecycle state and speculation bit.
module stbuf_ent
    import store_buffer_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alloc_i,
    input  logic [ADDR_LEN-1:0]    waddr_i,
    input  logic [DATA_LEN-1:0]    wdata_i,
    input  logic [SPECTAG_LEN-1:0] wspectag_i,
    input  logic                   wspecbit_i,
    input  logic                   commit_i,
    input  logic                   drain_i,
    input  logic                   prmiss_i,
    input  logic                   prsuccess_i,
    input  logic [SPECTAG_LEN-1:0] prtag_i,
    input  logic [SPECTAG_LEN-1:0] specfixtag_i,
    output logic [1:0]             state_o,
    output logic [ADDR_LEN-1:0]    addr_o,
    output logic [DATA_LEN-1:0]    data_o,
    output logic                   kill_o
);

    logic [1:0]             state_q, state_d;
    logic                   specbit_q, specbit_d;
    logic [SPECTAG_LEN-1:0] spectag_q, spectag_d;
    stbuf_payload_t         payload_q, payload_d;
    logic                   resolve;

    assign resolve = prsuccess_i & ~prmiss_i;

    // Speculative, uncommitted stores under the kill mask are squashed
    assign kill_o = prmiss_i & (state_q == ST_PEND) & specbit_q
                  & (|(spectag_q & specfixtag_i)) & ~commit_i;

    assign state_o = state_q;
    assign addr_o  = payload_q.addr;
    assign data_o  = payload_q.data;

    // Next-state: resolve clears specbit, allocate/commit/free move the lifecycle
    always_comb begin
        state_d   = state_q;
        specbit_d = specbit_q;
        spectag_d = spectag_q;
        payload_d = payload_q;
        if ((state_q != ST_FREE) && resolve && (spectag_q == prtag_i)) begin
            specbit_d = 1'b0;
        end
        if (alloc_i) begin
            state_d        = ST_PEND;
            specbit_d      = wspecbit_i & ~(resolve && (wspectag_i == prtag_i));
            spectag_d      = wspectag_i;
            payload_d.addr = waddr_i;
            payload_d.data = wdata_i;
        end
        if (commit_i) begin
            state_d = ST_COMM;
        end
        if (drain_i || kill_o) begin
            state_d = ST_FREE;
        end
    end

    // Lifecycle state and specbit, cleared by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_FREE;
            specbit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            specbit_q <= specbit_d;
        end
    end

    // Payload and tag storage; only meaningful while the entry is not FREE
    always_ff @(posedge clk) begin
        payload_q <= payload_d;
        spectag_q <= spectag_d;
    end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer between execute and data memory with retire, drain,
// mispredict kill/rewind and optional load forwarding (macro STBUF_FWD_EN).
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned ENT_NUM = STBUF_ENT_NUM
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [ADDR_LEN-1:0]    waddr,
    input  logic [DATA_LEN-1:0]    wdata,
    input  logic [SPECTAG_LEN-1:0] wspectag,
    input  logic                   wspecbit,
    input  logic                   prmiss,
    input  logic                   prsuccess,
    input  logic [SPECTAG_LEN-1:0] prtag,
    input  logic [SPECTAG_LEN-1:0] specfixtag,
    input  logic [1:0]             retire_st,
    output logic                   mem_we,
    input  logic                   mem_rdy,
    output logic [ADDR_LEN-1:0]    mem_addr,
    output logic [DATA_LEN-1:0]    mem_data,
    input  logic [ADDR_LEN-1:0]    ld_addr,
    output logic                   fwd_hit,
    output logic [DATA_LEN-1:0]    fwd_data,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned SEL   = $clog2(ENT_NUM);
    localparam int unsigned PTR_W = SEL + 1;

    logic [PTR_W-1:0] head_q, head_d, com_q, com_d, tail_q, tail_d;
    logic [PTR_W-1:0] count, pend_cnt, com_p1, rewind_ptr, scan_p;
    logic [SEL-1:0]   head_idx, com_idx, com1_idx, tail_idx;
    logic             wr_en, drain, any_kill;

    logic [ENT_NUM-1:0]  ent_alloc, ent_commit, ent_drain, ent_kill;
    logic [1:0]          ent_state [ENT_NUM];
    logic [ADDR_LEN-1:0] ent_addr  [ENT_NUM];
    logic [DATA_LEN-1:0] ent_data  [ENT_NUM];

    assign count    = tail_q - head_q;
    assign pend_cnt = tail_q - com_q;
    assign com_p1   = com_q + PTR_W'(1);
    assign head_idx = head_q[SEL-1:0];
    assign com_idx  = com_q[SEL-1:0];
    assign com1_idx = com_p1[SEL-1:0];
    assign tail_idx = tail_q[SEL-1:0];

    assign full  = (count == PTR_W'(ENT_NUM));
    assign empty = (count == '0);

    assign wr_en    = we & ~full & ~prmiss;
    assign mem_we   = (ent_state[head_idx] == ST_COMM);
    assign mem_addr = ent_addr[head_idx];
    assign mem_data = ent_data[head_idx];
    assign drain    = mem_we & mem_rdy;
    assign any_kill = |ent_kill;

    // Per-entry strobes for allocate at tail, commit at com, drain at head
    always_comb begin
        ent_alloc            = '0;
        ent_commit           = '0;
        ent_drain            = '0;
        ent_alloc[tail_idx]  = wr_en;
        ent_drain[head_idx]  = drain;
        ent_commit[com_idx]  = (retire_st != 2'd0);
        ent_commit[com1_idx] = retire_st[1];
    end

    for (genvar i = 0; i < ENT_NUM; i++) begin : g_ent
        stbuf_ent u_ent (
            .clk          (clk),
            .reset        (reset),
            .alloc_i      (ent_alloc[i]),
            .waddr_i      (waddr),
            .wdata_i      (wdata),
            .wspectag_i   (wspectag),
            .wspecbit_i   (wspecbit),
            .commit_i     (ent_commit[i]),
            .drain_i      (ent_drain[i]),
            .prmiss_i     (prmiss),
            .prsuccess_i  (prsuccess),
            .prtag_i      (prtag),
            .specfixtag_i (specfixtag),
            .state_o      (ent_state[i]),
            .addr_o       (ent_addr[i]),
            .data_o       (ent_data[i]),
            .kill_o       (ent_kill[i])
        );
    end

    // Oldest killed entry, scanning young-to-old from com so the oldest wins
    always_comb begin
        rewind_ptr = tail_q;
        scan_p     = com_q;
        for (int k = int'(ENT_NUM) - 1; k >= 0; k--) begin
            scan_p = com_q + PTR_W'(k);
            if (ent_kill[scan_p[SEL-1:0]]) begin
                rewind_ptr = scan_p;
            end
        end
    end

    // Pointer next-state
    always_comb begin
        head_d = head_q + PTR_W'(drain);
        com_d  = com_q + PTR_W'(retire_st);
        tail_d = tail_q;
        if (prmiss) begin
            if (any_kill) begin
                tail_d = rewind_ptr;
            end
        end else if (wr_en) begin
            tail_d = tail_q + PTR_W'(1);
        end
    end

    // Pointer registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q <= '0;
            com_q  <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            com_q  <= com_d;
            tail_q <= tail_d;
        end
    end

`ifdef STBUF_FWD_EN
    logic [PTR_W-1:0] fwd_p;
    logic [1:0]       unused_ld_lo;

    assign unused_ld_lo = ld_addr[1:0];

    // Word-match forwarding, scanning old-to-young so the youngest match wins
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_p    = head_q;
        for (int unsigned k = 0; k < ENT_NUM; k++) begin
            fwd_p = head_q + PTR_W'(k);
            if (!prmiss && (ent_state[fwd_p[SEL-1:0]] != ST_FREE)
                && (ent_addr[fwd_p[SEL-1:0]][ADDR_LEN-1:2] == ld_addr[ADDR_LEN-1:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = ent_data[fwd_p[SEL-1:0]];
            end
        end
    end
`else
    logic [ADDR_LEN-1:0] unused_ld_addr;

    assign unused_ld_addr = ld_addr;
    assign fwd_hit        = 1'b0;
    assign fwd_data       = '0;
`endif

`ifndef SYNTHESIS
    // Protocol checks on the producer and ROB sides
    always @(posedge clk) begin
        if (reset) begin
            assert (!(we && full && !prmiss))
                else $error("store_buffer: store presented while full");
            assert ((retire_st != 2'd3) && (PTR_W'(retire_st) <= pend_cnt))
                else $error("store_buffer: retire_st exceeds pending stores");
        end
    end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer.
module tb_store_buffer;
    import store_buffer_pkg::*;

`ifdef STBUF_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   we;
    logic [ADDR_LEN-1:0]    waddr;
    logic [DATA_LEN-1:0]    wdata;
    logic [SPECTAG_LEN-1:0] wspectag;
    logic                   wspecbit;
    logic                   prmiss, prsuccess;
    logic [SPECTAG_LEN-1:0] prtag, specfixtag;
    logic [1:0]             retire_st;
    logic                   mem_we, mem_rdy;
    logic [ADDR_LEN-1:0]    mem_addr;
    logic [DATA_LEN-1:0]    mem_data;
    logic [ADDR_LEN-1:0]    ld_addr;
    logic                   fwd_hit;
    logic [DATA_LEN-1:0]    fwd_data;
    logic                   full, empty;

    int n_chk  = 0;
    int n_fail = 0;

    store_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .wspectag   (wspectag),
        .wspecbit   (wspecbit),
        .prmiss     (prmiss),
        .prsuccess  (prsuccess),
        .prtag      (prtag),
        .specfixtag (specfixtag),
        .retire_st  (retire_st),
        .mem_we     (mem_we),
        .mem_rdy    (mem_rdy),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .ld_addr    (ld_addr),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; waddr = '0; wdata = '0; wspectag = '0; wspecbit = 1'b0;
        prmiss = 1'b0; prsuccess = 1'b0; prtag = '0; specfixtag = '0;
        retire_st = 2'd0; mem_rdy = 1'b0; ld_addr = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [4:0] tag, input logic sb);
        we = 1'b1; waddr = a; wdata = d; wspectag = tag; wspecbit = sb;
        tick();
        we = 1'b0;
    endtask

    task automatic ret(input logic [1:0] n);
        retire_st = n;
        tick();
        retire_st = 2'd0;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        #3;
        // Reset values
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_fwd_hit", 64'(fwd_hit), 64'd0);
        chk("rst_fwd_data", 64'(fwd_data), 64'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Fill to full, drain one, allocate one more
        wr(32'h10, 32'h1, 5'd0, 1'b0);
        chk("fill_empty", 64'(empty), 64'd0);
        wr(32'h14, 32'h2, 5'd0, 1'b0);
        wr(32'h18, 32'h3, 5'd0, 1'b0);
        chk("fill3_full", 64'(full), 64'd0);
        wr(32'h1C, 32'h4, 5'd0, 1'b0);
        chk("fill4_full", 64'(full), 64'd1);
        chk("fill4_tail", 64'(dut.tail_q), 64'h4);
        ret(2'd1);
        chk("fill_mem_we", 64'(mem_we), 64'd1);
        chk("fill_mem_addr", 64'(mem_addr), 64'h10);
        chk("fill_mem_data", 64'(mem_data), 64'h1);
        chk("fill_still_full", 64'(full), 64'd1);
        mem_rdy = 1'b1;
        tick();
        mem_rdy = 1'b0;
        chk("drain1_full", 64'(full), 64'd0);
        chk("drain1_mem_we", 64'(mem_we), 64'd0);
        wr(32'h20, 32'h5, 5'd0, 1'b0);
        chk("realloc_full", 64'(full), 64'd1);
        chk("realloc_tail", 64'(dut.tail_q), 64'h5);
        ret(2'd2);
        ret(2'd2);
        mem_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_seq_we", 64'(mem_we), 64'd1);
            chk("drain_seq_data", 64'(mem_data), 64'(i + 2));
            tick();
        end
        mem_rdy = 1'b0;
        chk("drain_all_empty", 64'(empty), 64'd1);
        chk("drain_all_we", 64'(mem_we), 64'd0);

        // Basic store, retire, drain
        wr(32'h100, 32'hDEAD, 5'd0, 1'b0);
        chk("basic_pend_we", 64'(mem_we), 64'd0);
        chk("basic_empty0", 64'(empty), 64'd0);
        ret(2'd1);
        chk("basic_mem_we", 64'(mem_we), 64'd1);
        chk("basic_mem_addr", 64'(mem_addr), 64'h100);
        chk("basic_mem_data", 64'(mem_data), 64'hDEAD);
        mem_rdy = 1'b1;
        tick();
        mem_rdy = 1'b0;
        chk("basic_empty1", 64'(empty), 64'd1);

        // Mispredict kill from a fresh reset
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        wr(32'h300, 32'hA0, 5'd0, 1'b0);
        retire_st = 2'd1;
        wr(32'h304, 32'hA1, 5'b00010, 1'b1);
        retire_st = 2'd0;
        wr(32'h308, 32'hA2, 5'b00100, 1'b1);
        chk("kill_pre_tail", 64'(dut.tail_q), 64'h3);
        chk("kill_pre_mem_data", 64'(mem_data), 64'hA0);
        prmiss = 1'b1; specfixtag = 5'b00110; mem_rdy = 1'b1;
        we = 1'b1; waddr = 32'h3FC; wdata = 32'hBAD; ld_addr = 32'h300;
        #1;
        chk("kill_fwd_gated", 64'(fwd_hit), 64'd0);
        chk("kill_mem_we", 64'(mem_we), 64'd1);
        tick();
        idle();
        chk("kill_tail", 64'(dut.tail_q), 64'h1);
        chk("kill_empty", 64'(empty), 64'd1);
        chk("kill_mem_we_after", 64'(mem_we), 64'd0);

        // Forwarding, youngest match wins
        wr(32'h200, 32'h11, 5'd0, 1'b0);
        wr(32'h200, 32'h22, 5'd0, 1'b0);
        ld_addr = 32'h202;
        #1;
        chk("fwd_hit", 64'(fwd_hit), 64'(FWD_EN));
        chk("fwd_data", 64'(fwd_data), FWD_EN ? 64'h22 : 64'h0);
        ld_addr = 32'h204;
        #1;
        chk("fwd_miss_hit", 64'(fwd_hit), 64'd0);
        chk("fwd_miss_data", 64'(fwd_data), 64'd0);
        ld_addr = 32'h203;
        ret(2'd2);
        chk("fwd_comm_mem_data", 64'(mem_data), 64'h11);
        chk("fwd_comm_data", 64'(fwd_data), FWD_EN ? 64'h22 : 64'h0);
        mem_rdy = 1'b1;
        tick();
        chk("fwd_draining_hit", 64'(fwd_hit), 64'(FWD_EN));
        chk("fwd_draining_data", 64'(fwd_data), FWD_EN ? 64'h22 : 64'h0);
        tick();
        mem_rdy = 1'b0;
        chk("fwd_gone_hit", 64'(fwd_hit), 64'd0);
        chk("fwd_gone_empty", 64'(empty), 64'd1);
        ld_addr = '0;

        // Resolve and write in the same cycle; later mispredict must spare it
        prsuccess = 1'b1; prtag = 5'b00001;
        wr(32'h400, 32'h77, 5'b00001, 1'b1);
        prsuccess = 1'b0; prtag = '0;
        wr(32'h404, 32'h78, 5'b00001, 1'b1);
        chk("spec_tail_pre", 64'(dut.tail_q), 64'h5);
        prmiss = 1'b1; specfixtag = 5'b00001;
        tick();
        idle();
        chk("spec_tail_post", 64'(dut.tail_q), 64'h4);
        chk("spec_survivor", 64'(empty), 64'd0);
        ret(2'd1);
        chk("spec_mem_addr", 64'(mem_addr), 64'h400);
        mem_rdy = 1'b1;
        tick();
        mem_rdy = 1'b0;
        chk("spec_empty", 64'(empty), 64'd1);

        // Reset while a drain is stalled
        wr(32'h500, 32'h90, 5'd0, 1'b0);
        wr(32'h504, 32'h91, 5'd0, 1'b0);
        wr(32'h508, 32'h92, 5'd0, 1'b0);
        wr(32'h50C, 32'h93, 5'd0, 1'b0);
        ret(2'd2);
        ret(2'd2);
        chk("midrst_pre_full", 64'(full), 64'd1);
        chk("midrst_pre_we", 64'(mem_we), 64'd1);
        reset = 1'b0;
        #1;
        chk("midrst_mem_we", 64'(mem_we), 64'd0);
        chk("midrst_full", 64'(full), 64'd0);
        chk("midrst_empty", 64'(empty), 64'd1);
        chk("midrst_fwd_hit", 64'(fwd_hit), 64'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_empty", 64'(empty), 64'd1);
        chk("post_rst_mem_we", 64'(mem_we), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
